// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
//
// Purpose : FSM state encoding, default operand width and counter sizing
//           helper used by seq_divider.
// Ports   : none (package)

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Step counter width for a given operand width; counts WIDTH-1 down to 0.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
//
// Purpose : shifts {partial_rem, shreg} left by one, trial-subtracts the
//           divisor magnitude and keeps or restores the partial remainder.
//           The subtract lives here on its own so it can be replaced by a
//           faster adder without touching the sequencer.
// Ports   : i_partial_rem  - current partial remainder (WIDTH)
//           i_shreg        - dividend bits still to consume / quotient so far
//           i_divisor_mag  - |divisor| (WIDTH, unsigned)
//           o_partial_rem  - partial remainder after this step
//           o_shreg        - shift register after this step (new quotient LSB)

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_partial_rem,
  input  logic [WIDTH-1:0] i_shreg,
  input  logic [WIDTH-1:0] i_divisor_mag,
  output logic [WIDTH-1:0] o_partial_rem,
  output logic [WIDTH-1:0] o_shreg
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;

  assign w_shifted = {i_partial_rem, i_shreg[WIDTH-1]};
  // One spare bit above the WIDTH+1 trial so an unsigned divisor near 2^WIDTH
  // still produces a clean borrow.
  assign w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor_mag};
  // A successful trial is always below the divisor, so both top bits are 0;
  // any set bit there means the subtraction went negative.
  assign w_ge      = (w_diff[WIDTH+1:WIDTH] == 2'b00);

  assign o_partial_rem = w_ge ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign o_shreg       = {i_shreg[WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative signed restoring divider (quotient/remainder)
//
// Purpose : accepts dividend/divisor on start, runs WIDTH restoring steps on
//           magnitudes, then applies sign fixup and registers the results.
//           Optional macro SEQ_DIVIDER_UNSIGNED_EN adds unsigned_op, which
//           treats operands as unsigned and skips sign fixup.
// Ports   : clk, reset (async, active-high)
//           start        - request, sampled only in IDLE
//           unsigned_op  - (SEQ_DIVIDER_UNSIGNED_EN only) unsigned operation
//           dividend     - two's-complement dividend, sampled with start
//           divisor      - two's-complement divisor, sampled with start
//           busy         - operation in flight
//           done         - one-cycle completion pulse
//           quotient     - registered quotient (LO)
//           remainder    - registered remainder (HI)
//           div_by_zero  - registered, set with done when divisor was 0

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_dvs_mag;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dbz;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_signed_op;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic             w_dvs_zero;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_shreg;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  assign w_signed_op = ~unsigned_op;
`else
  assign w_signed_op = 1'b1;
`endif

  assign w_dvd_neg  = w_signed_op & dividend[WIDTH-1];
  assign w_dvs_neg  = w_signed_op & divisor[WIDTH-1];
  assign w_dvs_zero = (divisor == '0);
  // Magnitudes are WIDTH-bit unsigned, so negating MIN_INT yields 2^(WIDTH-1).
  assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag  = w_dvs_neg ? -divisor  : divisor;

  // On divide by zero the shift register still holds |dividend|, so routing
  // it to the remainder and re-applying the dividend sign returns the
  // original dividend.
  assign w_q_mag = r_dbz ? '0      : r_shreg;
  assign w_r_mag = r_dbz ? r_shreg : r_rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_partial_rem (r_rem),
    .i_shreg       (r_shreg),
    .i_divisor_mag (r_dvs_mag),
    .o_partial_rem (w_step_rem),
    .o_shreg       (w_step_shreg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FIX waits for the counter to reach 0: normal operations arrive with 0,
  // divide by zero arrives with 1 so its completion lands two cycles out.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_dvs_zero ? FIX : RUN;
      RUN:     if (r_cnt == '0) w_next = FIX;
      FIX:     if (r_cnt == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_rem         <= '0;
      r_shreg       <= '0;
      r_dvs_mag     <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_dbz         <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rem     <= '0;
            r_shreg   <= w_dvd_mag;
            r_dvs_mag <= w_dvs_mag;
            r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg   <= w_dvd_neg;
            r_dbz     <= w_dvs_zero;
            r_cnt     <= w_dvs_zero ? CNT_W'(1) : CNT_W'(WIDTH - 1);
          end
        end
        RUN: begin
          r_rem   <= w_step_rem;
          r_shreg <= w_step_shreg;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_quotient    <= r_q_neg ? -w_q_mag : w_q_mag;
            r_remainder   <= r_r_neg ? -w_r_mag : w_r_mag;
            r_div_by_zero <= r_dbz;
            r_done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider

module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  logic        unsigned_op;
`endif

  int n_checks;
  int n_fail;
  int done_seen;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    .unsigned_op (unsigned_op),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation starting in the current cycle (just after an edge),
  // optionally pulses start with other operands inj_at cycles into the run,
  // and returns in the done cycle so a following call starts back-to-back.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input int inj_at);
    int  n;
    bit  got;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      if (inj_at > 0 && n == inj_at) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (n == 1) begin
        check({tag, ".busy_run"}, {31'd0, busy}, 32'd1);
        check({tag, ".done_low"}, {31'd0, done}, 32'd0);
      end
      if (done) got = 1'b1;
    end
    check({tag, ".latency"}, n, exp_lat);
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    check({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    done_seen = 0;
    reset     = 1'b1;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    unsigned_op = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.quotient", quotient, 32'd0);
    check("rst.remainder", remainder, 32'd0);
    check("rst.dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_div("p100_7",   32'd100,        32'd7,          33, 32'd14,         32'd2,          1'b0, 0);
    do_div("n100_7",   32'hFFFFFF9C,   32'd7,          33, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 0);
    do_div("p100_n7",  32'd100,        32'hFFFFFFF9,   33, 32'hFFFFFFF2,   32'd2,          1'b0, 0);
    do_div("n100_n7",  32'hFFFFFF9C,   32'hFFFFFFF9,   33, 32'd14,         32'hFFFFFFFE,   1'b0, 0);
    do_div("min_m1",   32'h80000000,   32'hFFFFFFFF,   33, 32'h80000000,   32'd0,          1'b0, 0);
    do_div("min_p1",   32'h80000000,   32'd1,          33, 32'h80000000,   32'd0,          1'b0, 0);
    do_div("dbz",      32'd1234,       32'd0,           2, 32'd0,          32'd1234,       1'b1, 0);
    do_div("dbz_neg",  32'hFFFFFF38,   32'd0,           2, 32'd0,          32'hFFFFFF38,   1'b1, 0);
    do_div("after_dbz",32'd7,          32'd7,          33, 32'd1,          32'd0,          1'b0, 0);
    do_div("small_big",32'd5,          32'd9,          33, 32'd0,          32'd5,          1'b0, 0);
    do_div("inject",   32'd1000,       32'd10,         33, 32'd100,        32'd0,          1'b0, 5);

    // Abort a run: outputs must clear immediately and no done may follow.
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.done", {31'd0, done}, 32'd0);
    check("abort.quotient", quotient, 32'd0);
    check("abort.remainder", remainder, 32'd0);
    check("abort.dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("abort.no_done", done_seen, 32'd0);

    do_div("p50_5",    32'd50,         32'd5,          33, 32'd10,         32'd0,          1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
